// File: rtl/wb_regfile_gen2.sv
// wb_regfile_gen2: writeback mux with sub-word load extraction, bypassed register file and retire counter
module wb_regfile_gen2 #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int OFF_W  = $clog2(XLEN/8),
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_stall,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [1:0]        wb_sel,
  input  logic [XLEN-1:0]   wb_alu_result,
  input  logic [XLEN-1:0]   wb_mem_rdata,
  input  logic [XLEN-1:0]   wb_pc_plus4,
  input  logic [1:0]        wb_mem_size,
  input  logic              wb_mem_unsigned,
  input  logic [OFF_W-1:0]  wb_mem_off,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              wb_commit,
  output logic [XLEN-1:0]   wb_wdata,
  output logic [CNT_W-1:0]  retire_count
);
  logic [OFF_W-1:0]           lane;
  logic [XLEN-1:0]            shifted, ld_b, ld_h, ld_w, ld_data;
  logic                       we;
  logic [NREGS-1:0][XLEN-1:0] regs;
  assign wb_commit = wb_valid & ~wb_stall;
  assign we = wb_commit & wb_regwrite & (wb_rd != '0);
  // lane offset is the load offset aligned down to the access size; dword always starts at 0
  always_comb begin
    lane = wb_mem_size == 2'd0 ? wb_mem_off :
           wb_mem_size == 2'd1 ? wb_mem_off & ~OFF_W'(1) :
           wb_mem_size == 2'd2 ? wb_mem_off & ~OFF_W'(3) : '0;
    shifted = wb_mem_rdata >> {lane, 3'b000};
    ld_b = wb_mem_unsigned ? XLEN'(shifted[7:0]) : XLEN'($signed(shifted[7:0]));
    ld_h = wb_mem_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
    ld_w = wb_mem_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
    ld_data = wb_mem_size == 2'd0 ? ld_b :
              wb_mem_size == 2'd1 ? ld_h :
              (wb_mem_size == 2'd2 || XLEN == 32) ? ld_w : shifted;
    wb_wdata = wb_sel == 2'd1 ? ld_data : wb_sel == 2'd2 ? wb_pc_plus4 : wb_alu_result;
  end
  assign rs1_data = (reset || rs1_addr == '0) ? '0 : (we && wb_rd == rs1_addr) ? wb_wdata : regs[rs1_addr];
  assign rs2_data = (reset || rs2_addr == '0) ? '0 : (we && wb_rd == rs2_addr) ? wb_wdata : regs[rs2_addr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      regs <= '0;
      retire_count <= '0;
    end else begin
      if (we) regs[wb_rd] <= wb_wdata;
      if (wb_commit) retire_count <= retire_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_wb_regfile_gen2.sv
// tb_wb_regfile_gen2: randomized bench comparing a 32-bit/CNT_W=4 and a 64-bit/8-reg instance against a behavioural model
module tb_wb_regfile_gen2;
  logic        clk = 0, reset = 0, valid = 0, stall = 0, regwrite = 0, uns = 0, chk_en = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [1:0]  sel = 0, size = 0;
  logic [2:0]  off = 0;
  logic [63:0] alu = 0, rdata = 0, pc = 0;
  logic [31:0] a_rs1, a_rs2, a_wdata;
  logic        a_commit, b_commit;
  logic [3:0]  a_cnt;
  logic [63:0] b_rs1, b_rs2, b_wdata, b_cnt;
  int checks = 0, failures = 0;
  logic [63:0] ma [32];
  logic [63:0] mb [8];
  logic [3:0]  ca;
  logic [63:0] cb;

  always #5 clk = ~clk;

  wb_regfile_gen2 #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .wb_valid(valid), .wb_stall(stall), .wb_regwrite(regwrite),
    .wb_rd(rd), .wb_sel(sel), .wb_alu_result(alu[31:0]), .wb_mem_rdata(rdata[31:0]),
    .wb_pc_plus4(pc[31:0]), .wb_mem_size(size), .wb_mem_unsigned(uns), .wb_mem_off(off[1:0]),
    .rs1_addr(rs1), .rs2_addr(rs2), .rs1_data(a_rs1), .rs2_data(a_rs2),
    .wb_commit(a_commit), .wb_wdata(a_wdata), .retire_count(a_cnt));

  wb_regfile_gen2 #(.XLEN(64), .NREGS(8), .CNT_W(64)) dut_b (
    .clk(clk), .reset(reset), .wb_valid(valid), .wb_stall(stall), .wb_regwrite(regwrite),
    .wb_rd(rd[2:0]), .wb_sel(sel), .wb_alu_result(alu), .wb_mem_rdata(rdata),
    .wb_pc_plus4(pc), .wb_mem_size(size), .wb_mem_unsigned(uns), .wb_mem_off(off),
    .rs1_addr(rs1[2:0]), .rs2_addr(rs2[2:0]), .rs1_data(b_rs1), .rs2_data(b_rs2),
    .wb_commit(b_commit), .wb_wdata(b_wdata), .retire_count(b_cnt));

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask

  // access width in bytes, aligned-down start byte, then mask and extend
  function automatic logic [63:0] ld_m(input int xlen);
    int n, o, base;
    logic [63:0] d, v, m;
    n = size == 0 ? 1 : size == 1 ? 2 : (size == 2 || xlen == 32) ? 4 : 8;
    o = xlen == 32 ? int'(off[1:0]) : int'(off);
    d = xlen == 32 ? {32'd0, rdata[31:0]} : rdata;
    base = (o / n) * n;
    v = d >> (base * 8);
    m = n == 8 ? '1 : (64'd1 << (n * 8)) - 64'd1;
    v = v & m;
    if (!uns && v[n*8-1]) v = v | ~m;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] wd_m(input int xlen);
    logic [63:0] v;
    v = sel == 1 ? ld_m(xlen) : sel == 2 ? pc : alu;
    return xlen == 32 ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] rd_a(input logic [4:0] a);
    if (reset || a == 0) return 0;
    if (valid && !stall && regwrite && rd == a) return wd_m(32);
    return ma[a];
  endfunction

  function automatic logic [63:0] rd_b(input logic [2:0] a);
    if (reset || a == 0) return 0;
    if (valid && !stall && regwrite && rd[2:0] == a) return wd_m(64);
    return mb[a];
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) ma[i] <= 0;
      for (int i = 0; i < 8; i++) mb[i] <= 0;
      ca <= 0;
      cb <= 0;
    end else if (valid && !stall) begin
      ca <= ca + 4'd1;
      cb <= cb + 64'd1;
      if (regwrite && rd != 0) ma[rd] <= wd_m(32);
      if (regwrite && rd[2:0] != 0) mb[rd[2:0]] <= wd_m(64);
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("a_rs1", {32'd0, a_rs1}, rd_a(rs1));
      chk("a_rs2", {32'd0, a_rs2}, rd_a(rs2));
      chk("a_wdata", {32'd0, a_wdata}, wd_m(32));
      chk("a_commit", {63'd0, a_commit}, {63'd0, valid & ~stall});
      chk("a_cnt", {60'd0, a_cnt}, {60'd0, ca});
      chk("b_rs1", b_rs1, rd_b(rs1[2:0]));
      chk("b_rs2", b_rs2, rd_b(rs2[2:0]));
      chk("b_wdata", b_wdata, wd_m(64));
      chk("b_commit", {63'd0, b_commit}, {63'd0, valid & ~stall});
      chk("b_cnt", b_cnt, cb);
    end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3 reset = 1;
    #1 chk_en = 1;
    cyc;
    cyc;
    reset = 0;
    // reset lands mid-cycle while a write to x5 is pending
    valid = 1; regwrite = 1; rd = 5; sel = 0; alu = 64'h1234; rs1 = 5;
    #2 reset = 1;
    cyc;
    reset = 0; valid = 0;
    #2 chk("rst_x5", {32'd0, a_rs1}, 0);
    chk("rst_cnt", {60'd0, a_cnt}, 0);
    cyc;
    // sub-word loads into x3
    valid = 1; regwrite = 1; rd = 3; rs1 = 3; sel = 1; size = 0; uns = 0; off = 2; rdata = 64'h1280_3456;
    #2 chk("lb_s", {32'd0, a_wdata}, 64'hFFFF_FF80);
    chk("lb_s_byp", {32'd0, a_rs1}, 64'hFFFF_FF80);
    chk("lb_s_64", b_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    cyc;
    uns = 1;
    #2 chk("lbu", {32'd0, a_wdata}, 64'h0000_0080);
    cyc;
    uns = 0; size = 1; off = 2; rdata = 64'h8001_0000;
    #2 chk("lh_s", {32'd0, a_wdata}, 64'hFFFF_8001);
    chk("lh_s_64", b_wdata, 64'hFFFF_FFFF_FFFF_8001);
    cyc;
    valid = 0;
    #2 chk("x3_held", {32'd0, a_rs1}, 64'hFFFF_8001);
    cyc;
    // dual bypass, then x0 write discarded
    valid = 1; regwrite = 1; rd = 7; sel = 0; alu = 64'hDEAD_BEEF; rs1 = 7; rs2 = 7;
    #2 chk("byp1", {32'd0, a_rs1}, 64'hDEAD_BEEF);
    chk("byp2", {32'd0, a_rs2}, 64'hDEAD_BEEF);
    chk("byp_64", b_rs2, 64'hDEAD_BEEF);
    cyc;
    rd = 0; alu = 64'hFFFF_FFFF; rs1 = 0;
    #2 chk("x0_byp", {32'd0, a_rs1}, 0);
    cyc;
    valid = 0;
    #2 chk("x0", {32'd0, a_rs1}, 0);
    chk("x7", {32'd0, a_rs2}, 64'hDEAD_BEEF);
    chk("cnt5", {60'd0, a_cnt}, 5);
    // three stalled cycles with a write to x9 held
    valid = 1; stall = 1; regwrite = 1; rd = 9; alu = 64'h55; rs1 = 9;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_x9", {32'd0, a_rs1}, 0);
      chk("stall_cnt", {60'd0, a_cnt}, 5);
      cyc;
    end
    stall = 0;
    cyc;
    valid = 0;
    #2 chk("post_x9", {32'd0, a_rs1}, 64'h55);
    chk("post_cnt", {60'd0, a_cnt}, 6);
    // 17 commits wrap the 4-bit counter; link writes to x10
    reset = 1;
    cyc;
    reset = 0; rd = 10; rs1 = 10; sel = 2;
    for (int i = 0; i < 17; i++) begin
      valid = 1; regwrite = (i % 3 == 0); pc = 64'h1000 + 64'(4 * i);
      if (i == 0) #2 chk("pc4", {32'd0, a_wdata}, 64'h1000);
      cyc;
    end
    valid = 0;
    #2 chk("wrap_a", {60'd0, a_cnt}, 1);
    chk("cnt_b", b_cnt, 17);
    chk("x10", {32'd0, a_rs1}, 64'h103C);
    // 64-bit dword and upper-word loads
    valid = 1; regwrite = 1; rd = 2; rs1 = 2; sel = 1; size = 3; off = 0; uns = 0;
    rdata = 64'h0123_4567_89AB_CDEF;
    #2 chk("ld_64", b_wdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_32sz3", {32'd0, a_wdata}, 64'h89AB_CDEF);
    cyc;
    size = 2; off = 4; rdata = 64'h8000_0000_0000_0001;
    #2 chk("lw_hi", b_wdata, 64'hFFFF_FFFF_8000_0000);
    chk("lw_32", {32'd0, a_wdata}, 64'h1);
    cyc;
    valid = 0;
    #2 chk("x2_64", b_rs1, 64'hFFFF_FFFF_8000_0000);
    cyc;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      regwrite = $urandom_range(0, 3) != 0;
      rd = 5'($urandom);
      rs1 = $urandom_range(0, 2) == 0 ? rd : 5'($urandom);
      rs2 = $urandom_range(0, 2) == 0 ? rd : 5'($urandom);
      sel = 2'($urandom);
      size = 2'($urandom);
      uns = 1'($urandom);
      off = 3'($urandom);
      alu = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      pc = {$urandom, $urandom};
      cyc;
    end
    reset = 0;
    valid = 0;
    cyc;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
